// File: rtl/e16_event_packer.sv
// Packs nonzero e16 controller output vectors with an inter-event cycle delta into a FIFO.
// Optional macro E16_EVENT_PACKER_DEDUP_EN suppresses repeats of the last pushed vector.
module e16_event_packer #(
    parameter int DEPTH   = 8,
    parameter int DELTA_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [17:0]               y_vec,
    input  logic                      ev_ready,
    output logic                      ev_valid,
    output logic [18+DELTA_W-1:0]     ev_data,
    output logic [$clog2(DEPTH):0]    ev_count,
    output logic                      ovf,
    output logic [7:0]                drop_cnt,
    output logic                      busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = 18 + DELTA_W;
    localparam logic [DELTA_W-1:0] DELTA_MAX = '1;
    localparam logic [AW:0]        FULL_CNT  = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [AW:0]         count_r;
    logic [AW:0]         count_s;
    logic [AW-1:0]       wptr_r;
    logic [AW-1:0]       rptr_r;
    logic [DELTA_W-1:0]  delta_r;
    logic                ev_valid_r;
    logic                busy_r;
    logic                ovf_r;
    logic [7:0]          drop_cnt_r;
    logic [DW-1:0]       mem_r [DEPTH];

    logic                start_s;
    logic                run_s;
    logic                event_s;
    logic                full_s;
    logic                pop_s;
    logic                push_s;
    logic                drop_s;

    assign start_s = (state_r == IDLE) && en;
    assign run_s   = (state_r == RUN);
    assign full_s  = (count_r == FULL_CNT);
    // ev_valid_r tracks count_r != 0, so a pop can never hit an empty FIFO
    assign pop_s   = ev_valid_r && ev_ready;
    assign push_s  = event_s && (!full_s || pop_s);
    assign drop_s  = event_s && full_s && !pop_s;

`ifdef E16_EVENT_PACKER_DEDUP_EN
    logic [17:0] last_r;

    // Event detection: nonzero and different from the last vector actually pushed
    always_comb begin
        event_s = 1'b0;
        if (run_s && (y_vec != 18'd0) && (y_vec != last_r)) begin
            event_s = 1'b1;
        end else begin
            event_s = 1'b0;
        end
    end

    // Last pushed vector, restarted on every capture session
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r <= 18'd0;
        end else if (start_s) begin
            last_r <= 18'd0;
        end else if (push_s) begin
            last_r <= y_vec;
        end
    end
`else
    // Event detection: every nonzero vector sampled in RUN
    always_comb begin
        event_s = 1'b0;
        if (run_s && (y_vec != 18'd0)) begin
            event_s = 1'b1;
        end else begin
            event_s = 1'b0;
        end
    end
`endif

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + {{AW{1'b0}}, 1'b1};
            2'b01:   count_s = count_r - {{AW{1'b0}}, 1'b1};
            default: count_s = count_r;
        endcase
    end

    // Next-state logic; leaving decisions use post-update occupancy
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (en) state_s = RUN;
                else    state_s = IDLE;
            end
            RUN: begin
                if (en)                       state_s = RUN;
                else if (count_s != {(AW+1){1'b0}}) state_s = DRAIN;
                else                          state_s = IDLE;
            end
            DRAIN: begin
                if (en)                       state_s = RUN;
                else if (count_s == {(AW+1){1'b0}}) state_s = IDLE;
                else                          state_s = DRAIN;
            end
            default: state_s = IDLE;
        endcase
    end

    // State, pointers, occupancy and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            count_r    <= {(AW+1){1'b0}};
            wptr_r     <= {AW{1'b0}};
            rptr_r     <= {AW{1'b0}};
            ev_valid_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            count_r    <= count_s;
            ev_valid_r <= (count_s != {(AW+1){1'b0}});
            busy_r     <= (state_s != IDLE);
            if (push_s) wptr_r <= wptr_r + {{(AW-1){1'b0}}, 1'b1};
            if (pop_s)  rptr_r <= rptr_r + {{(AW-1){1'b0}}, 1'b1};
        end
    end

    // Inter-event delta: restarts per session, cleared on every event (pushed or dropped)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delta_r <= {DELTA_W{1'b0}};
        end else if (start_s) begin
            delta_r <= {DELTA_W{1'b0}};
        end else if (run_s) begin
            if (event_s)                  delta_r <= {DELTA_W{1'b0}};
            else if (delta_r != DELTA_MAX) delta_r <= delta_r + {{(DELTA_W-1){1'b0}}, 1'b1};
        end
    end

    // Sticky overflow and saturating drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r      <= 1'b0;
            drop_cnt_r <= 8'd0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
            if (drop_cnt_r != 8'hFF) drop_cnt_r <= drop_cnt_r + 8'd1;
        end
    end

    // FIFO storage, no reset needed since reads are gated by ev_valid
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wptr_r] <= {delta_r, y_vec};
    end

    assign ev_data  = mem_r[rptr_r];
    assign ev_valid = ev_valid_r;
    assign ev_count = count_r;
    assign ovf      = ovf_r;
    assign drop_cnt = drop_cnt_r;
    assign busy     = busy_r;
endmodule

// File: tb/tb_e16_event_packer.sv
// Directed bench for e16_event_packer with a queue scoreboard of expected FIFO entries.
module tb_e16_event_packer;
    localparam int DEPTH   = 8;
    localparam int DELTA_W = 8;
    localparam int DW      = 18 + DELTA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [17:0]       y_vec;
    logic              ev_ready;
    logic              ev_valid;
    logic [DW-1:0]     ev_data;
    logic [3:0]        ev_count;
    logic              ovf;
    logic [7:0]        drop_cnt;
    logic              busy;

    logic [DW-1:0]     sb[$];
    int                n_chk  = 0;
    int                n_fail = 0;

    e16_event_packer #(.DEPTH(DEPTH), .DELTA_W(DELTA_W)) dut (
        .clk(clk), .rst(rst), .en(en), .y_vec(y_vec), .ev_ready(ev_ready),
        .ev_valid(ev_valid), .ev_data(ev_data), .ev_count(ev_count),
        .ovf(ovf), .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; a pop happening on that edge is scored against the queue head
    task automatic tick();
        logic [DW-1:0] e;
        if (ev_valid === 1'b1 && ev_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_pop", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("pop_data", 32'(ev_data), 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [17:0] v);
        sb.push_back({d, v});
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; y_vec = 18'd0; ev_ready = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        ev_ready = 1'b1;
        y_vec    = 18'd0;
        for (int i = 0; i < 20 && ev_valid === 1'b1; i++) tick();
        chk({tag, "_valid_after_drain"}, 32'(ev_valid), 32'd0);
        chk({tag, "_count_after_drain"}, 32'(ev_count), 32'd0);
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        ev_ready = 1'b0;
    endtask

    initial begin
        // Reset values
        rst = 1'b1; en = 1'b0; y_vec = 18'd0; ev_ready = 1'b0;
        #1;
        chk("rst_valid", 32'(ev_valid), 32'd0);
        chk("rst_count", 32'(ev_count), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        do_reset();

        // Basic capture: edge-1 vector ignored, delta=2 on the edge-4 event
        en = 1'b1; y_vec = 18'h00001;
        tick();
        chk("b_busy_run", 32'(busy), 32'd1);
        chk("b_no_capture_e1", 32'(ev_count), 32'd0);
        y_vec = 18'h00000; tick(); tick();
        chk("b_empty_e3", 32'(ev_valid), 32'd0);
        y_vec = 18'h00008; push_exp(8'd2, 18'h00008); tick();
        chk("b_valid_e4", 32'(ev_valid), 32'd1);
        chk("b_count_e4", 32'(ev_count), 32'd1);
        drain("basic");

        // Overflow: 10 events into 8 entries
        do_reset();
        en = 1'b1; tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            y_vec = 18'h100 + 18'(i);
            if (i < 8) push_exp((i == 0) ? 8'd1 : 8'd0, 18'h100 + 18'(i));
            tick();
        end
        y_vec = 18'd0;
        chk("ovf_count", 32'(ev_count), 32'd8);
        chk("ovf_flag", 32'(ovf), 32'd1);
        chk("ovf_drop", 32'(drop_cnt), 32'd2);
        drain("ovf");
        chk("ovf_sticky", 32'(ovf), 32'd1);

        // Full FIFO with simultaneous pop and push
        do_reset();
        en = 1'b1; tick();
        for (int i = 0; i < 8; i++) begin
            y_vec = 18'h200 + 18'(i); push_exp(8'd0, 18'h200 + 18'(i)); tick();
        end
        y_vec = 18'h2FF; ev_ready = 1'b1; push_exp(8'd0, 18'h2FF); tick();
        chk("full_pp_count", 32'(ev_count), 32'd8);
        chk("full_pp_ovf", 32'(ovf), 32'd0);
        chk("full_pp_drop", 32'(drop_cnt), 32'd0);
        drain("full_pp");

        // Delta saturation
        do_reset();
        en = 1'b1; tick();
        y_vec = 18'd0;
        repeat (301) tick();
        y_vec = 18'h00003; push_exp(8'd255, 18'h00003); tick();
        y_vec = 18'd0;
        chk("sat_count", 32'(ev_count), 32'd1);
        drain("sat");

        // DRAIN behaviour
        do_reset();
        en = 1'b1; tick();
        for (int i = 0; i < 3; i++) begin
            y_vec = 18'h300 + 18'(i); push_exp(8'd0, 18'h300 + 18'(i)); tick();
        end
        en = 1'b0; y_vec = 18'd0; tick();
        chk("drain_busy0", 32'(busy), 32'd1);
        ev_ready = 1'b1;
        tick(); chk("drain_busy1", 32'(busy), 32'd1);
        tick(); chk("drain_busy2", 32'(busy), 32'd1);
        tick(); chk("drain_idle", 32'(busy), 32'd0);
        chk("drain_valid", 32'(ev_valid), 32'd0);
        ev_ready = 1'b0;

        // Reset mid-DRAIN
        en = 1'b1; tick();
        for (int i = 0; i < 3; i++) begin
            y_vec = 18'h310 + 18'(i); push_exp(8'd0, 18'h310 + 18'(i)); tick();
        end
        en = 1'b0; y_vec = 18'd0; tick();
        ev_ready = 1'b1; tick();
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(ev_valid), 32'd0);
        chk("midrst_count", 32'(ev_count), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        sb.delete();
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("postrst_valid", 32'(ev_valid), 32'd0);
        ev_ready = 1'b0;

        // Repeated vector handling
        do_reset();
        en = 1'b1; tick();
        y_vec = 18'h00010;
`ifdef E16_EVENT_PACKER_DEDUP_EN
        push_exp(8'd0, 18'h00010);
        repeat (3) tick();
        y_vec = 18'h00020; push_exp(8'd2, 18'h00020); tick();
        y_vec = 18'd0;
        chk("dedup_count", 32'(ev_count), 32'd2);
`else
        for (int i = 0; i < 3; i++) begin
            push_exp(8'd0, 18'h00010); tick();
        end
        y_vec = 18'h00020; push_exp(8'd0, 18'h00020); tick();
        y_vec = 18'd0;
        chk("nodedup_count", 32'(ev_count), 32'd4);
`endif
        drain("dedup");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
